// File: rtl/vol_i2c_pkg.sv
// Shared types and constants for the WM8731 headphone-volume I2C sequencer.
package vol_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUS,
    WRITE,
    RETRY_WAIT,
    DONE
  } vol_state_t;

  // Codec register address (LHPOUT) and the both-channels bit that rides in
  // the LSB of the register-address byte.
  localparam logic [6:0]  LHPOUT_ADDR = 7'h02;
  localparam logic        LRHPBOTH    = 1'b1;
  localparam int unsigned LZCEN_BIT   = 7;

  localparam int unsigned NUM_BYTES  = 3;
  localparam int unsigned BYTE_CNT_W = 2;

  // Width of the quarter-period counter for a given clock/SCL ratio.
  function automatic int unsigned div_w(input int unsigned clk_hz, input int unsigned i2c_hz);
    int unsigned q;
    q = clk_hz / (4 * i2c_hz);
    return (q < 2) ? 1 : $clog2(q);
  endfunction

endpackage

// File: rtl/i2c_wr_engine.sv
// Three-byte I2C master write: START, 3 x (8 data + ACK), STOP.
// Each bit uses four quarter-periods: SDA change, SCL rise, sample, SCL fall.
module i2c_wr_engine
  import vol_i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned I2C_HZ = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] wr_data,
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_oe,
  output logic        busy,
  output logic        done,
  output logic        nack
);

  localparam int unsigned QDIV = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned QW   = div_w(CLK_HZ, I2C_HZ);

  typedef enum logic [1:0] {E_IDLE, E_START, E_BIT, E_STOP} emode_t;

  emode_t                mode;
  logic [QW-1:0]         qcnt;
  logic [1:0]            ph;
  logic [3:0]            bit_idx;
  logic [BYTE_CNT_W-1:0] byte_idx;
  logic [23:0]           sh;
  logic                  sda_s1;
  logic                  sda_s2;
  logic                  step;

  assign step = (qcnt == QW'(QDIV - 1));

  // Bit sequencer: quarter-period divider, bit/byte counters and pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= E_IDLE;
      qcnt     <= '0;
      ph       <= 2'd0;
      bit_idx  <= 4'd0;
      byte_idx <= '0;
      sh       <= '0;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      done   <= 1'b0;
      if (mode == E_IDLE) begin
        qcnt <= '0;
        ph   <= 2'd0;
        if (start) begin
          mode     <= E_START;
          busy     <= 1'b1;
          nack     <= 1'b0;
          sh       <= wr_data;
          bit_idx  <= 4'd0;
          byte_idx <= '0;
        end
      end else begin
        qcnt <= step ? '0 : qcnt + 1'b1;
        if (step) begin
          ph <= ph + 2'd1;
          case (mode)
            E_START: begin
              if (ph == 2'd0) begin
                sda_oe <= 1'b1;
              end else begin
                scl  <= 1'b0;
                mode <= E_BIT;
                ph   <= 2'd0;
              end
            end
            E_BIT: begin
              case (ph)
                2'd0: sda_oe <= (bit_idx == 4'd8) ? 1'b0 : ~sh[23];
                2'd1: scl <= 1'b1;
                2'd2: if (bit_idx == 4'd8 && sda_s2) nack <= 1'b1;
                default: begin
                  scl <= 1'b0;
                  if (bit_idx == 4'd8) begin
                    bit_idx <= 4'd0;
                    if (nack || byte_idx == BYTE_CNT_W'(NUM_BYTES - 1)) begin
                      mode <= E_STOP;
                    end else begin
                      byte_idx <= byte_idx + BYTE_CNT_W'(1);
                    end
                  end else begin
                    bit_idx <= bit_idx + 4'd1;
                    sh      <= {sh[22:0], 1'b0};
                  end
                end
              endcase
            end
            E_STOP: begin
              case (ph)
                2'd0: sda_oe <= 1'b1;
                2'd1: scl <= 1'b1;
                2'd2: sda_oe <= 1'b0;
                default: begin
                  mode <= E_IDLE;
                  busy <= 1'b0;
                  done <= 1'b1;
                end
              endcase
            end
            default: mode <= E_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/vol_i2c_ctrl.sv
// Headphone-volume sequencer: waits for the HPS PIO to leave the I2C bus idle,
// takes it, writes WM8731 LHPOUT (both channels) and hands the bus back.
// Build option: define VOL_ZC_EN to set LZCEN so the codec applies the change
// at zero-cross.
module vol_i2c_ctrl
  import vol_i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned I2C_HZ    = 100000,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned IDLE_GAP  = 64,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic [6:0] vol_level,
  input  logic       vol_req,
  output logic       vol_req_rcvd,
  output logic       vol_set_done,
  output logic       vol_err,
  input  logic       pio_scl,
  input  logic       pio_sda_oe,
  output logic       i2c_scl,
  output logic       i2c_sda_oe,
  input  logic       i2c_sda_in,
  output logic       bus_owned
);

  localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);
  localparam int unsigned RTY_W = $clog2(RETRY_MAX + 2);

`ifdef VOL_ZC_EN
  localparam logic ZC = 1'b1;
`else
  localparam logic ZC = 1'b0;
`endif

  vol_state_t       state;
  logic [6:0]       vol_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             req_s1;
  logic             req_s2;
  logic             req_s3;
  logic             eng_start;
  logic             eng_scl;
  logic             eng_sda_oe;
  logic             eng_busy;
  logic             eng_done;
  logic             eng_nack;
  logic [7:0]       data_byte;
  logic [23:0]      wr_data;
  logic             pio_idle;

  // Volume data byte with the optional zero-cross enable in bit 7.
  always_comb begin
    data_byte            = {1'b0, vol_lat};
    data_byte[LZCEN_BIT] = ZC;
  end

  assign wr_data  = {DEV_ADDR, 1'b0, LHPOUT_ADDR, LRHPBOTH, data_byte};
  assign pio_idle = pio_scl && !pio_sda_oe;

  i2c_wr_engine #(
    .CLK_HZ(CLK_HZ),
    .I2C_HZ(I2C_HZ)
  ) u_engine (
    .clk    (clk_50),
    .rst_n  (reset_n),
    .start  (eng_start),
    .wr_data(wr_data),
    .sda_in (i2c_sda_in),
    .scl    (eng_scl),
    .sda_oe (eng_sda_oe),
    .busy   (eng_busy),
    .done   (eng_done),
    .nack   (eng_nack)
  );

  // Request handshake, bus acquisition and retry control.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      vol_lat      <= 7'd0;
      gap_cnt      <= '0;
      retry_cnt    <= '0;
      req_s1       <= 1'b0;
      req_s2       <= 1'b0;
      req_s3       <= 1'b0;
      eng_start    <= 1'b0;
      vol_req_rcvd <= 1'b0;
      vol_set_done <= 1'b0;
      vol_err      <= 1'b0;
      bus_owned    <= 1'b0;
    end else begin
      req_s1    <= vol_req;
      req_s2    <= req_s1;
      req_s3    <= req_s2;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_s2 && !req_s3) begin
            vol_lat      <= vol_level;
            vol_req_rcvd <= 1'b1;
            vol_err      <= 1'b0;
            retry_cnt    <= '0;
            gap_cnt      <= '0;
            state        <= WAIT_BUS;
          end
        end
        WAIT_BUS: begin
          if (!pio_idle) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_W'(IDLE_GAP)) begin
            if (!eng_busy) begin
              gap_cnt   <= '0;
              bus_owned <= 1'b1;
              eng_start <= 1'b1;
              state     <= WRITE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (eng_done) begin
            if (eng_nack) begin
              state <= RETRY_WAIT;
            end else begin
              bus_owned    <= 1'b0;
              vol_set_done <= 1'b1;
              state        <= DONE;
            end
          end
        end
        RETRY_WAIT: begin
          bus_owned <= 1'b0;
          if (retry_cnt == RTY_W'(RETRY_MAX)) begin
            vol_err      <= 1'b1;
            vol_set_done <= 1'b1;
            state        <= DONE;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            gap_cnt   <= '0;
            state     <= WAIT_BUS;
          end
        end
        DONE: begin
          if (!req_s2) begin
            vol_req_rcvd <= 1'b0;
            vol_set_done <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pin mux: PIO pass-through unless the engine owns the bus; released in reset.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      i2c_scl    <= 1'b1;
      i2c_sda_oe <= 1'b0;
    end else if (bus_owned) begin
      i2c_scl    <= eng_scl;
      i2c_sda_oe <= eng_sda_oe;
    end else begin
      i2c_scl    <= pio_scl;
      i2c_sda_oe <= pio_sda_oe;
    end
  end

endmodule

// File: tb/tb_vol_i2c_ctrl.sv
// Directed bench for vol_i2c_ctrl with a behavioural WM8731 I2C slave.
module tb_vol_i2c_ctrl;

  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] vol_level = 7'd0;
  logic       vol_req = 1'b0;
  logic       vol_req_rcvd;
  logic       vol_set_done;
  logic       vol_err;
  logic       pio_scl = 1'b1;
  logic       pio_sda_oe = 1'b0;
  logic       i2c_scl;
  logic       i2c_sda_oe;
  logic       i2c_sda_in;
  logic       bus_owned;

  int checks = 0;
  int passed = 0;

`ifdef VOL_ZC_EN
  localparam logic [7:0] ZC_MASK = 8'h80;
`else
  localparam logic [7:0] ZC_MASK = 8'h00;
`endif

  vol_i2c_ctrl #(
    .CLK_HZ(1600000),
    .I2C_HZ(100000)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .vol_level   (vol_level),
    .vol_req     (vol_req),
    .vol_req_rcvd(vol_req_rcvd),
    .vol_set_done(vol_set_done),
    .vol_err     (vol_err),
    .pio_scl     (pio_scl),
    .pio_sda_oe  (pio_sda_oe),
    .i2c_scl     (i2c_scl),
    .i2c_sda_oe  (i2c_sda_oe),
    .i2c_sda_in  (i2c_sda_in),
    .bus_owned   (bus_owned)
  );

  always #5 clk_50 = ~clk_50;

  // Behavioural slave: decodes START/STOP/bytes and drives ACK or NACK.
  logic       ack_drv = 1'b0;
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  logic [7:0] sh_in = 8'd0;
  logic [7:0] rx_q[$];
  int         bitn = 0;
  int         byte_in_frame = 0;
  int         starts = 0;
  int         stops = 0;
  int         scl_falls = 0;
  int         nack_mode = 0;
  logic       sda_line;

  assign sda_line   = ~(i2c_sda_oe | ack_drv);
  assign i2c_sda_in = sda_line;

  always @(negedge clk_50) begin
    if (i2c_scl && scl_p && sda_p && !sda_line) begin
      starts++;
      bitn = 0;
      byte_in_frame = 0;
      ack_drv = 1'b0;
    end else if (i2c_scl && scl_p && !sda_p && sda_line) begin
      stops++;
      bitn = 0;
      ack_drv = 1'b0;
    end else if (i2c_scl && !scl_p) begin
      if (bitn < 8) sh_in = {sh_in[6:0], sda_line};
      bitn++;
    end else if (!i2c_scl && scl_p) begin
      scl_falls++;
      if (bitn == 8) begin
        rx_q.push_back(sh_in);
        ack_drv = !((nack_mode == 1 && byte_in_frame == 0) ||
                    (nack_mode == 2 && byte_in_frame == 0 && starts == 1));
      end else if (bitn == 9) begin
        ack_drv = 1'b0;
        bitn = 0;
        byte_in_frame++;
      end
    end
    scl_p = i2c_scl;
    sda_p = sda_line;
  end

  task automatic clear_slave();
    rx_q.delete();
    bitn = 0;
    byte_in_frame = 0;
    starts = 0;
    stops = 0;
    scl_falls = 0;
    ack_drv = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  // Waits for 0:vol_req_rcvd, 1:bus_owned, 2:vol_set_done; n=-1 on timeout.
  task automatic wait_sig(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if ((which == 0 && vol_req_rcvd) || (which == 1 && bus_owned) ||
          (which == 2 && vol_set_done)) begin
        n = i;
        break;
      end
    end
  endtask

  // Drops vol_req and reports cycles until both flags clear and whether they moved together.
  task automatic drop_req(output int n, output bit together);
    vol_req = 1'b0;
    n = -1;
    together = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (vol_req_rcvd != vol_set_done) together = 1'b0;
      if (!vol_req_rcvd && !vol_set_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    pio_scl = 1'b0;
    pio_sda_oe = 1'b1;
    tick(2);
    checks++; if (i2c_scl !== 1'b1) $display("FAIL reset_scl got %b want 1", i2c_scl); else passed++;
    checks++; if (i2c_sda_oe !== 1'b0) $display("FAIL reset_sda_oe got %b want 0", i2c_sda_oe); else passed++;
    checks++; if ({vol_req_rcvd, vol_set_done, vol_err, bus_owned} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {vol_req_rcvd, vol_set_done, vol_err, bus_owned});
    else passed++;
    reset_n = 1'b1;
    tick(2);
    checks++; if (i2c_scl !== 1'b0) $display("FAIL pass_scl_low got %b want 0", i2c_scl); else passed++;
    checks++; if (i2c_sda_oe !== 1'b1) $display("FAIL pass_sda_oe got %b want 1", i2c_sda_oe); else passed++;
    pio_scl = 1'b1;
    pio_sda_oe = 1'b0;
    tick(2);
    checks++; if (i2c_scl !== 1'b1) $display("FAIL pass_scl_high got %b want 1", i2c_scl); else passed++;
    clear_slave();
  endtask

  task automatic test_basic_write();
    int n;
    bit tog;
    clear_slave();
    vol_level = 7'h79;
    vol_req = 1'b1;
    wait_sig(0, 10, n);
    checks++; if (n < 1 || n > 3) $display("FAIL rcvd_latency got %0d want 1..3", n); else passed++;
    checks++; if (bus_owned !== 1'b0) $display("FAIL early_bus got %b want 0", bus_owned); else passed++;
    wait_sig(1, 200, n);
    checks++; if (n < 64 || n > 66) $display("FAIL idle_gap got %0d want 64..66", n); else passed++;
    wait_sig(2, 2000, n);
    checks++; if (n < 0) $display("FAIL basic_done got timeout want done"); else passed++;
    checks++; if (rx_q.size() !== 3) $display("FAIL basic_nbytes got %0d want 3", rx_q.size());
    else begin
      passed++;
      checks++; if (rx_q[0] !== 8'h34) $display("FAIL byte0 got %h want 34", rx_q[0]); else passed++;
      checks++; if (rx_q[1] !== 8'h05) $display("FAIL byte1 got %h want 05", rx_q[1]); else passed++;
      checks++; if (rx_q[2] !== (8'h79 | ZC_MASK)) $display("FAIL byte2 got %h want %h", rx_q[2], 8'h79 | ZC_MASK); else passed++;
    end
    tick(20);
    checks++; if ({starts, stops} !== {32'd1, 32'd1}) $display("FAIL basic_frames got %0d/%0d want 1/1", starts, stops); else passed++;
    checks++; if ({vol_set_done, vol_req_rcvd, vol_err, bus_owned} !== 4'b1100)
      $display("FAIL basic_hold got %b want 1100", {vol_set_done, vol_req_rcvd, vol_err, bus_owned});
    else passed++;
    drop_req(n, tog);
    checks++; if (n < 1 || n > 3 || !tog) $display("FAIL basic_release got %0d/%0b want 1..3/1", n, tog); else passed++;
  endtask

  task automatic test_pio_busy();
    int n;
    bit tog;
    pio_sda_oe = 1'b1;
    tick(2);
    clear_slave();
    vol_level = 7'h3F;
    vol_req = 1'b1;
    tick(500);
    checks++; if (scl_falls !== 0 || bus_owned !== 1'b0)
      $display("FAIL busy_hold got falls=%0d own=%b want 0/0", scl_falls, bus_owned);
    else passed++;
    pio_sda_oe = 1'b0;
    wait_sig(1, 200, n);
    checks++; if (n < 64 || n > 67) $display("FAIL busy_gap got %0d want 64..67", n); else passed++;
    clear_slave();
    wait_sig(2, 2000, n);
    checks++; if (rx_q.size() !== 3) $display("FAIL busy_nbytes got %0d want 3", rx_q.size());
    else begin
      passed++;
      checks++; if (rx_q[2] !== (8'h3F | ZC_MASK)) $display("FAIL busy_byte2 got %h want %h", rx_q[2], 8'h3F | ZC_MASK); else passed++;
    end
    drop_req(n, tog);
    checks++; if (n < 1 || !tog) $display("FAIL busy_release got %0d/%0b want >0/1", n, tog); else passed++;
  endtask

  task automatic test_nack_all();
    int n;
    bit tog;
    clear_slave();
    nack_mode = 1;
    vol_level = 7'h10;
    vol_req = 1'b1;
    wait_sig(2, 5000, n);
    checks++; if (n < 0) $display("FAIL nack_done got timeout want done"); else passed++;
    tick(10);
    checks++; if (vol_err !== 1'b1 || vol_set_done !== 1'b1) $display("FAIL nack_err got %b%b want 11", vol_err, vol_set_done); else passed++;
    checks++; if (starts !== 4 || stops !== 4) $display("FAIL nack_attempts got %0d/%0d want 4/4", starts, stops); else passed++;
    checks++; if (rx_q.size() !== 4) $display("FAIL nack_nbytes got %0d want 4", rx_q.size()); else passed++;
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'h34) $display("FAIL nack_addr%0d got %h want 34", i, rx_q[i]); else passed++;
    end
    drop_req(n, tog);
    checks++; if (n < 1 || !tog || vol_err !== 1'b1)
      $display("FAIL nack_release got %0d/%0b err=%b want >0/1/1", n, tog, vol_err);
    else passed++;
    nack_mode = 0;
    clear_slave();
    vol_level = 7'h22;
    vol_req = 1'b1;
    wait_sig(0, 10, n);
    checks++; if (vol_err !== 1'b0) $display("FAIL err_clear got %b want 0", vol_err); else passed++;
    wait_sig(2, 2000, n);
    checks++; if (vol_err !== 1'b0 || rx_q.size() !== 3) $display("FAIL recover got err=%b n=%0d want 0/3", vol_err, rx_q.size()); else passed++;
    drop_req(n, tog);
  endtask

  task automatic test_nack_first();
    int n;
    bit tog;
    clear_slave();
    nack_mode = 2;
    vol_level = 7'h55;
    vol_req = 1'b1;
    wait_sig(2, 3000, n);
    tick(20);
    checks++; if (vol_err !== 1'b0) $display("FAIL retry_err got %b want 0", vol_err); else passed++;
    checks++; if (starts !== 2 || stops !== 2) $display("FAIL retry_frames got %0d/%0d want 2/2", starts, stops); else passed++;
    checks++; if (rx_q.size() !== 4) $display("FAIL retry_nbytes got %0d want 4", rx_q.size());
    else begin
      passed++;
      checks++; if (rx_q[3] !== (8'h55 | ZC_MASK)) $display("FAIL retry_byte got %h want %h", rx_q[3], 8'h55 | ZC_MASK); else passed++;
    end
    nack_mode = 0;
    drop_req(n, tog);
  endtask

  task automatic test_reset_mid();
    int n;
    clear_slave();
    vol_level = 7'h66;
    vol_req = 1'b1;
    wait_sig(1, 200, n);
    tick(200);
    for (int i = 0; i < 50 && i2c_scl !== 1'b0; i++) tick(1);
    checks++; if (i2c_scl !== 1'b0 || rx_q.size() !== 1)
      $display("FAIL mid_setup got scl=%b n=%0d want 0/1", i2c_scl, rx_q.size());
    else passed++;
    reset_n = 1'b0;
    vol_req = 1'b0;
    #1;
    checks++; if (i2c_scl !== 1'b1 || i2c_sda_oe !== 1'b0)
      $display("FAIL mid_release got %b%b want 10", i2c_scl, i2c_sda_oe);
    else passed++;
    checks++; if ({vol_req_rcvd, vol_set_done, vol_err, bus_owned} !== 4'b0000)
      $display("FAIL mid_flags got %b want 0000", {vol_req_rcvd, vol_set_done, vol_err, bus_owned});
    else passed++;
    tick(3);
    reset_n = 1'b1;
    clear_slave();
    pio_scl = 1'b0;
    tick(2);
    checks++; if (i2c_scl !== 1'b0) $display("FAIL mid_pass_scl got %b want 0", i2c_scl); else passed++;
    pio_scl = 1'b1;
    pio_sda_oe = 1'b1;
    tick(2);
    checks++; if (i2c_scl !== 1'b1 || i2c_sda_oe !== 1'b1) $display("FAIL mid_pass_sda got %b%b want 11", i2c_scl, i2c_sda_oe); else passed++;
    pio_sda_oe = 1'b0;
    tick(4);
    checks++; if (vol_req_rcvd !== 1'b0) $display("FAIL mid_idle got %b want 0", vol_req_rcvd); else passed++;
    clear_slave();
  endtask

  task automatic test_early_drop();
    int n;
    int high;
    clear_slave();
    vol_level = 7'h0A;
    vol_req = 1'b1;
    wait_sig(1, 200, n);
    vol_req = 1'b0;
    wait_sig(2, 2000, n);
    checks++; if (n < 0 || rx_q.size() !== 3) $display("FAIL early_done got %0d/%0d want done/3", n, rx_q.size()); else passed++;
    high = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (vol_set_done) high++;
    end
    checks++; if (high !== 1) $display("FAIL early_pulse got %0d want 1", high); else passed++;
    checks++; if (vol_req_rcvd !== 1'b0 || bus_owned !== 1'b0) $display("FAIL early_idle got %b%b want 00", vol_req_rcvd, bus_owned); else passed++;
    vol_level = 7'h01;
    vol_req = 1'b1;
    wait_sig(0, 10, n);
    checks++; if (n < 1 || n > 3) $display("FAIL early_rearm got %0d want 1..3", n); else passed++;
    wait_sig(2, 2000, n);
    vol_req = 1'b0;
    tick(5);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_pio_busy();
    test_nack_all();
    test_nack_first();
    test_reset_mid();
    test_early_drop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
